// File: rtl/recovery_ctrl_pkg.sv
// Shared types and default timing constants for the lockstep recovery controller.
package ft_recovery_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_CORE_RST,
    ST_RESTORE,
    ST_RESUME,
    ST_FAIL
  } state_e;

  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_RST_CYCLES   = 2;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_CLEAN_WINDOW = 1024;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/recovery_ctrl_if.sv
// Comparator, SGPR read port and core control bundle of the recovery controller.
interface recovery_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  wb_valid_i;
  logic                  mismatch_i;
  logic [ADDR_WIDTH-1:0] sgpr_raddr_o;
  logic [DATA_WIDTH-1:0] sgpr_rdata_i;
  logic                  halt_o;
  logic                  core_rst_n_o;
  logic                  core_we_o;
  logic [ADDR_WIDTH-1:0] core_waddr_o;
  logic [DATA_WIDTH-1:0] core_wdata_o;
  logic                  busy_o;
  logic [7:0]            err_count_o;
  logic                  fatal_o;

  modport master (
    output wb_valid_i, mismatch_i, sgpr_rdata_i,
    input  sgpr_raddr_o, halt_o, core_rst_n_o, core_we_o, core_waddr_o,
           core_wdata_o, busy_o, err_count_o, fatal_o
  );

  modport slave (
    input  wb_valid_i, mismatch_i, sgpr_rdata_i,
    output sgpr_raddr_o, halt_o, core_rst_n_o, core_we_o, core_waddr_o,
           core_wdata_o, busy_o, err_count_o, fatal_o
  );
endinterface

// File: rtl/recovery_ctrl.sv
// Halts both cores on a lockstep mismatch, resets them, restores the register
// file from the SGPR copy and resumes; gives up after too many retries.
module recovery_ctrl
  import ft_recovery_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int CLEAN_WINDOW = DEF_CLEAN_WINDOW
) (
  input logic            clk,
  input logic            rst_n,
  recovery_ctrl_if.slave bus
);

  // One counter times HALT/CORE_RST and then serves as the restore address.
  localparam int CNT_W   = max2(ADDR_WIDTH, $clog2(max2(DRAIN_CYCLES, RST_CYCLES) + 1));
  localparam int RET_W   = $clog2(MAX_RETRY + 2);
  localparam int CLEAN_W = $clog2(CLEAN_WINDOW + 1);

  localparam logic [CNT_W-1:0]   DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FIRST_ADDR  = CNT_W'(1);
  localparam logic [RET_W-1:0]   RETRY_LIMIT = RET_W'(MAX_RETRY);
  localparam logic [CLEAN_W-1:0] CLEAN_DONE  = CLEAN_W'(CLEAN_WINDOW);

  state_e               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [RET_W-1:0]     retry_reg, retry_next, retry_inc;
  logic [CLEAN_W-1:0]   clean_reg, clean_next;
  logic [7:0]           err_reg, err_next;
  logic                 restoring;
  logic [DATA_WIDTH-1:0] wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      retry_reg <= '0;
      clean_reg <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      clean_reg <= clean_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    clean_next = clean_reg;
    err_next   = err_reg;
    retry_inc  = retry_reg + RET_W'(1);
    case (state_reg)
      ST_IDLE: begin
        if (bus.wb_valid_i && bus.mismatch_i) begin
          // A hit on the window-completion cycle still counts against the old retry value.
          err_next   = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;
          retry_next = retry_inc;
          clean_next = '0;
          if (retry_inc > RETRY_LIMIT) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_HALT;
            cnt_next   = DRAIN_LOAD;
          end
        end else if (clean_reg == CLEAN_DONE) begin
          retry_next = '0;
          clean_next = '0;
        end else begin
          clean_next = clean_reg + CLEAN_W'(1);
        end
      end
      ST_HALT: begin
        if (cnt_reg == '0) begin
          state_next = ST_CORE_RST;
          cnt_next   = RST_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_CORE_RST: begin
        if (cnt_reg == '0) begin
          state_next = ST_RESTORE;
          cnt_next   = FIRST_ADDR;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RESTORE: begin
        if (cnt_reg[ADDR_WIDTH-1:0] == '1) begin
          state_next = ST_RESUME;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RESUME: state_next = ST_IDLE;
      ST_FAIL:   state_next = ST_FAIL;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign restoring = (state_reg == ST_RESTORE);

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_wdata
    assign wdata[gi] = restoring & bus.sgpr_rdata_i[gi];
  end

  assign bus.halt_o       = (state_reg != ST_IDLE);
  assign bus.core_rst_n_o = (state_reg != ST_CORE_RST);
  assign bus.core_we_o    = restoring;
  assign bus.sgpr_raddr_o = restoring ? cnt_reg[ADDR_WIDTH-1:0] : '0;
  assign bus.core_waddr_o = restoring ? cnt_reg[ADDR_WIDTH-1:0] : '0;
  assign bus.core_wdata_o = wdata;
  assign bus.busy_o       = (state_reg != ST_IDLE) && (state_reg != ST_FAIL);
  assign bus.err_count_o  = err_reg;
  assign bus.fatal_o      = (state_reg == ST_FAIL);

endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed bench for recovery_ctrl: a per-cycle vector table for one full
// recovery plus hand-written retry, clean-window, mid-restore reset and saturation sequences.
module tb_recovery_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  recovery_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  recovery_ctrl_if #(.ADDR_WIDTH(2),  .DATA_WIDTH(8))  bus2 ();

  recovery_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAIN_CYCLES(4), .RST_CYCLES(2),
    .MAX_RETRY(3), .CLEAN_WINDOW(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Short-recovery instance with a high retry limit, used to reach err_count saturation.
  recovery_ctrl #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .DRAIN_CYCLES(1), .RST_CYCLES(1),
    .MAX_RETRY(300), .CLEAN_WINDOW(1024)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  logic [DW-1:0] sgpr [32];
  always_comb bus.sgpr_rdata_i = sgpr[bus.sgpr_raddr_o];
  always_comb bus2.sgpr_rdata_i = 8'hA5;

  typedef struct packed {
    logic          halt;
    logic          crst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic [7:0]    err;
    logic          fatal;
  } obs_t;

  typedef struct {
    logic rst_n;
    logic valid;
    logic mm;
    obs_t exp;
  } vec_t;

  localparam int NV = 52;
  vec_t tbl [NV];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic obs_t mk(logic h, logic cr, logic we, int addr, logic busy, int err, logic fatal);
    obs_t o;
    o.halt   = h;
    o.crst_n = cr;
    o.we     = we;
    o.waddr  = AW'(addr);
    o.raddr  = AW'(addr);
    o.wdata  = we ? DW'(addr) * 32'h11111111 : '0;
    o.busy   = busy;
    o.err    = 8'(err);
    o.fatal  = fatal;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.halt   = bus.halt_o;
    o.crst_n = bus.core_rst_n_o;
    o.we     = bus.core_we_o;
    o.waddr  = bus.core_waddr_o;
    o.raddr  = bus.sgpr_raddr_o;
    o.wdata  = bus.core_wdata_o;
    o.busy   = bus.busy_o;
    o.err    = bus.err_count_o;
    o.fatal  = bus.fatal_o;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got halt=%0b crst_n=%0b we=%0b waddr=%0d raddr=%0d wdata=%h busy=%0b err=%0d fatal=%0b; want halt=%0b crst_n=%0b we=%0b waddr=%0d raddr=%0d wdata=%h busy=%0b err=%0d fatal=%0b",
               name, act.halt, act.crst_n, act.we, act.waddr, act.raddr, act.wdata, act.busy, act.err, act.fatal,
               exp.halt, exp.crst_n, exp.we, exp.waddr, exp.raddr, exp.wdata, exp.busy, exp.err, exp.fatal);
    end else begin
      $display("ok   %s: halt=%0b crst_n=%0b we=%0b addr=%0d err=%0d fatal=%0b",
               name, act.halt, act.crst_n, act.we, act.waddr, act.err, act.fatal);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Called at a falling edge: reset for one rising edge, then release.
  task automatic do_reset();
    bus.wb_valid_i = 1'b0;
    bus.mismatch_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one acted-on mismatch; returns at the next falling edge.
  task automatic pulse_mm();
    bus.wb_valid_i = 1'b1;
    bus.mismatch_i = 1'b1;
    @(negedge clk);
    bus.wb_valid_i = 1'b0;
    bus.mismatch_i = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.halt_o && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int    c;
    int    we_cnt;
    string nm;

    for (int k = 0; k < 32; k++) sgpr[k] = DW'(k) * 32'h11111111;

    // One full recovery: mismatch at t=10, ignored mismatches at t=5 (no valid),
    // t=12 (HALT), t=20 (RESTORE) and t=48 (RESUME).
    for (int t = 0; t < NV; t++) begin
      int e;
      tbl[t].rst_n = 1'b1;
      tbl[t].valid = (t == 10 || t == 12 || t == 20 || t == 48);
      tbl[t].mm    = (t == 5 || t == 10 || t == 12 || t == 20 || t == 48);
      e = (t >= 11) ? 1 : 0;
      if (t <= 10)      tbl[t].exp = mk(1'b0, 1'b1, 1'b0, 0, 1'b0, e, 1'b0);
      else if (t <= 14) tbl[t].exp = mk(1'b1, 1'b1, 1'b0, 0, 1'b1, e, 1'b0);
      else if (t <= 16) tbl[t].exp = mk(1'b1, 1'b0, 1'b0, 0, 1'b1, e, 1'b0);
      else if (t <= 47) tbl[t].exp = mk(1'b1, 1'b1, 1'b1, t - 16, 1'b1, e, 1'b0);
      else if (t == 48) tbl[t].exp = mk(1'b1, 1'b1, 1'b0, 0, 1'b1, e, 1'b0);
      else              tbl[t].exp = mk(1'b0, 1'b1, 1'b0, 0, 1'b0, e, 1'b0);
    end

    bus.wb_valid_i  = 1'b0;
    bus.mismatch_i  = 1'b0;
    bus2.wb_valid_i = 1'b0;
    bus2.mismatch_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    we_cnt = 0;
    for (int t = 0; t < NV; t++) begin
      @(negedge clk);
      rst_n          = tbl[t].rst_n;
      bus.wb_valid_i = tbl[t].valid;
      bus.mismatch_i = tbl[t].mm;
      if (bus.core_we_o) we_cnt++;
      nm = $sformatf("vec%0d", t);
      check(nm, tbl[t].exp);
    end
    bus.wb_valid_i = 1'b0;
    bus.mismatch_i = 1'b0;
    check_int("restore_write_count", we_cnt, 31);

    // Back-to-back retries: the fourth exceeds the limit and latches FAIL.
    @(negedge clk);
    do_reset();
    check("reset_state", mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0));
    for (int i = 1; i <= 3; i++) begin
      pulse_mm();
      nm = $sformatf("retry%0d_halt", i);
      check(nm, mk(1'b1, 1'b1, 1'b0, 0, 1'b1, i, 1'b0));
      wait_idle(c);
      nm = $sformatf("retry%0d_len", i);
      check_int(nm, c, 38);
    end
    pulse_mm();
    check("fatal_entry", mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 4, 1'b1));
    bus.wb_valid_i = 1'b1;
    bus.mismatch_i = 1'b1;
    repeat (20) @(negedge clk);
    bus.wb_valid_i = 1'b0;
    bus.mismatch_i = 1'b0;
    check("fatal_sticky", mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 4, 1'b1));
    do_reset();
    check("fatal_cleared", mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0));

    // Clean window clears the retry count; exactly three more retries fit.
    pulse_mm();
    wait_idle(c);
    check_int("clean_first_len", c, 38);
    repeat (1100) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      pulse_mm();
      nm = $sformatf("post_clean%0d", i);
      check(nm, mk(1'b1, 1'b1, 1'b0, 0, 1'b1, i + 1, 1'b0));
      wait_idle(c);
    end
    pulse_mm();
    check("retry_restart_limit", mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 5, 1'b1));

    // Reset in the middle of RESTORE.
    do_reset();
    pulse_mm();
    c = 0;
    while (!(bus.core_we_o && bus.core_waddr_o == AW'(12)) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("restore_k12", mk(1'b1, 1'b1, 1'b1, 12, 1'b1, 1, 1'b0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_restore_reset", mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0));
    @(negedge clk);
    check("mid_restore_idle", mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0));

    // Saturation on the short-recovery instance under continuous mismatches.
    do_reset();
    check_int("dut2_reset_err", int'(bus2.err_count_o), 0);
    bus2.wb_valid_i = 1'b1;
    bus2.mismatch_i = 1'b1;
    repeat (2000) @(negedge clk);
    check_int("dut2_err_saturate", int'(bus2.err_count_o), 255);
    check_int("dut2_no_fatal", int'(bus2.fatal_o), 0);
    bus2.wb_valid_i = 1'b0;
    bus2.mismatch_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/recovery_ctrl.md
RECOVERY_CTRL -- requirements
Module: recovery_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, sets the register address width.
REQ-002 Parameter DATA_WIDTH, default 32, sets the register data width.
REQ-003 Parameter DRAIN_CYCLES, default 4, sets the pipeline-drain wait after halt.
REQ-004 Parameter RST_CYCLES, default 2, sets the core reset pulse length.
REQ-005 Parameter MAX_RETRY, default 3, sets the number of recoveries allowed before fatal.
REQ-006 Parameter CLEAN_WINDOW, default 1024, sets the clean cycles needed to clear the retry count.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset; synchronous, active-low.
REQ-009 wb_valid_i  input  1  a writeback from either core is present this cycle (we_a | we_b).
REQ-010 mismatch_i  input  1  comparator mismatch flag, meaningful only when wb_valid_i=1.
REQ-011 sgpr_raddr_o  output  ADDR_WIDTH  read address driven into the SGPR spare read port.
REQ-012 sgpr_rdata_i  input  DATA_WIDTH  SGPR read data, combinational from sgpr_raddr_o.
REQ-013 halt_o  output  1  stalls both cores (fetch disable) while high.
REQ-014 core_rst_n_o  output  1  active-low reset to both cores.
REQ-015 core_we_o, core_waddr_o (ADDR_WIDTH), core_wdata_o (DATA_WIDTH)  outputs  register-file restore write port to both cores.
REQ-016 busy_o  output  1  recovery in progress (state is not IDLE or FAIL).
REQ-017 err_count_o  output  8  total mismatches acted on; saturates at 255.
REQ-018 fatal_o  output  1  sticky: retry limit exceeded.

Function
REQ-019 The FSM states SHALL be IDLE, HALT, CORE_RST, RESTORE, RESUME and FAIL.
REQ-020 In IDLE, a cycle with wb_valid_i=1 and mismatch_i=1 SHALL move to HALT next cycle, increment err_count_o and increment the retry count.
- If the incremented retry count exceeds MAX_RETRY, the move SHALL be to FAIL instead of HALT.
REQ-021 halt_o SHALL be registered high from HALT entry through the end of RESUME, and high in FAIL.
REQ-022 HALT SHALL last exactly DRAIN_CYCLES cycles, then move to CORE_RST.
REQ-023 CORE_RST SHALL hold core_rst_n_o=0 for exactly RST_CYCLES cycles, then move to RESTORE.
REQ-024 RESTORE SHALL step an address k from 1 to 2^ADDR_WIDTH-1 (31 cycles at default), skipping x0.
- Each cycle: sgpr_raddr_o=k, core_we_o=1, core_waddr_o=k, core_wdata_o=sgpr_rdata_i (same-cycle combinational pass).
- After k=31 the FSM SHALL move to RESUME.
REQ-025 RESUME SHALL last one cycle with halt_o=1 and core_we_o=0, then move to IDLE; halt_o is low from the first IDLE cycle.
REQ-026 mismatch_i and wb_valid_i SHALL be ignored in every state except IDLE.
REQ-027 In IDLE, CLEAN_WINDOW consecutive cycles without an acted-on mismatch SHALL clear the retry count to 0.
- A mismatch on the same cycle the window completes SHALL count as a retry against the uncleared value.
REQ-028 FAIL SHALL be terminal until rst_n, with fatal_o=1, halt_o=1 and core_we_o=0.
REQ-029 err_count_o SHALL saturate at 255 and never wrap.
REQ-030 core_we_o SHALL be 0 in every state except RESTORE.
REQ-031 In every state except RESTORE, sgpr_raddr_o and core_waddr_o SHALL be 0.

Reset
REQ-032 When rst_n=0 at a clock edge, the block SHALL enter IDLE from any state, including mid-RESTORE and FAIL.
- All outputs and counters SHALL take their reset values: halt_o=0, core_rst_n_o=1, core_we_o=0, addresses 0, core_wdata_o=0, busy_o=0, err_count_o=0, fatal_o=0, retry count 0, clean-window counter 0.

Structure
REQ-033 Package ft_recovery_pkg SHALL hold the state enum and the default DRAIN_CYCLES, RST_CYCLES, MAX_RETRY and CLEAN_WINDOW constants.
REQ-034 The block SHALL be flat, with no sub-module.
- One shared down-counter SHALL time HALT and CORE_RST; the RESTORE address register doubles as its counter.

Verification
REQ-035 Single mismatch at cycle 10 -> halt_o high at 11; core_rst_n_o low for cycles 15-16; core_we_o high for 31 cycles with core_waddr_o 1..31; halt_o low after RESUME; err_count_o=1.
REQ-036 SGPR preloaded xk=k*0x11111111 -> restore writes match exactly; no write to x0.
REQ-037 mismatch_i=1 with wb_valid_i=0, and mismatch_i=1 during RESTORE -> no state change; err_count_o unchanged.
REQ-038 Four mismatches, each in the first IDLE cycle after RESUME -> fourth enters FAIL; fatal_o=1 sticky; rst_n clears it.
REQ-039 Mismatch, recovery, 1024 clean cycles, then three mismatches -> no FAIL; retry count restarted from 0.
REQ-040 rst_n low at RESTORE k=12 -> next cycle IDLE; core_we_o=0; core_rst_n_o=1; err_count_o=0.
